vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Source end of the vga_if pixel stream: generates hcount/vcount, sync and blanking for the 1024x768@60 display consumed by all draw/overlay stages (background, win screens, sprites). Free-running counters with optional pixel-enable stall. Drives rgb to black so downstream stages own all colour. Sits directly after the clock/reset block, ahead of the first draw stage.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, hsync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vsync width (lines)
V_BP, 29, vertical back porch (lines)
SYNC_ACTIVE, 1'b1, asserted level of hsync/vsync

Ports:
clk  in  1  pixel clock (65 MHz)
rst  in  1  asynchronous, active-high reset
pix_en  in  1  advance counters this cycle; low = hold all outputs
vga_out  vga_if.out  -  vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]
frame_start  out  1  one-cycle pulse coincident with first output pixel (0,0) of each frame
frame_cnt  out  16  frames completed since reset, wraps at 16'hFFFF->0

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806). Counters 11 bits; widths must hold H_TOTAL-1 / V_TOTAL-1.
- Reset (async assert, sync deassert handled upstream): hcount=0, vcount=0, hsync=vsync=~SYNC_ACTIVE, hblnk=vblnk=0, rgb=0, frame_start=0, frame_cnt=0.
- All outputs registered; computed from next counter values so hcount, vcount, sync, blnk in a given cycle describe the same pixel (zero skew between fields).
- Per cycle with pix_en=1: hcount_n = (hcount==H_TOTAL-1) ? 0 : hcount+1. vcount changes only on hcount wrap: vcount_n = (vcount==V_TOTAL-1) ? 0 : vcount+1.
- pix_en=0: every output holds, including frame_start (a held 1 stays 1; it represents pixel (0,0) still being presented).
- hblnk = 1 iff hcount in [H_ACTIVE, H_TOTAL-1]. vblnk = 1 iff vcount in [V_ACTIVE, V_TOTAL-1].
- hsync = SYNC_ACTIVE iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048,1183]; vsync = SYNC_ACTIVE iff vcount in [771,776]. vsync edges align with hcount=0 transitions.
- rgb = 12'h000 always (downstream stages overwrite; keeps blanking black).
- frame_start = 1 iff output (hcount,vcount) == (0,0) following an advance from (H_TOTAL-1,V_TOTAL-1); not asserted for the post-reset (0,0) pixel.
- frame_cnt increments on the same advance that raises frame_start.
- Simultaneous h- and v-wrap: single transition (H_TOTAL-1,V_TOTAL-1)->(0,0); no intermediate state.
- rst mid-line/mid-frame: immediate return to reset values; next frame begins at (0,0) with no partial sync pulse extended.
- No illegal states reachable; if counters ever exceed TOTAL-1 they wrap to 0 on the next advance.

Test Plan:
- Reset release, pix_en=1: hcount 0,1,2,... each cycle; after 1344 cycles hcount=0, vcount=1; hsync asserted exactly cycles with hcount 1048..1183 (136 cycles).
- Run one full frame (1344*806=1,083,264 cycles): vsync asserted for lines 771..776 (6 lines, 8064 cycles); vblnk for lines 768..805; frame_start pulses once at end, frame_cnt=1.
- Blanking check: at hcount=1023 hblnk=0, at 1024 hblnk=1, at 0 hblnk=0; rgb=0 every cycle.
- pix_en toggled 1-0-0-1 at hcount=1343,vcount=805: outputs hold for 2 cycles, then (0,0) with frame_start=1 held across the stall cycles only if already asserted; frame_cnt increments once.
- Assert rst at (hcount=600,vcount=400, hsync inactive) and mid-hsync (hcount=1100): outputs return to reset values asynchronously before next clk edge; restart from (0,0), frame_cnt=0.
- frame_cnt force-preload to 16'hFFFF via 65535 frames (or backdoor): next frame wrap -> 0 with frame_start pulse.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bundle shared by the timing source and every draw/overlay stage.
// The timing generator drives it through the 'out' modport; draw stages read it through 'in'.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 1024x768@60 raster timing source with pixel-enable stall.
// Every output is a flop loaded from the next-pixel values, so all fields describe the same pixel.
module vga_timing_gen #(
   parameter int   H_ACTIVE    = 1024,
   parameter int   H_FP        = 24,
   parameter int   H_SYNC      = 136,
   parameter int   H_BP        = 160,
   parameter int   V_ACTIVE    = 768,
   parameter int   V_FP        = 3,
   parameter int   V_SYNC      = 6,
   parameter int   V_BP        = 29,
   parameter logic SYNC_ACTIVE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   vga_if.out          vga_out,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_BLNK_ON  = 11'(H_ACTIVE);
   localparam logic [10:0] V_BLNK_ON  = 11'(V_ACTIVE);
   localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_OFF = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] hcount_q, hcount_d;
   logic [10:0] vcount_q, vcount_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        hblnk_q, hblnk_d;
   logic        vblnk_q, vblnk_d;
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic        h_wrap;
   logic        v_wrap;
   logic [10:0] h_next;
   logic [10:0] v_next;

   always_comb begin
      // >= rather than == so an out-of-range count recovers on the next advance
      h_wrap = (hcount_q >= H_LAST);
      v_wrap = (vcount_q >= V_LAST);
      h_next = h_wrap ? 11'd0 : hcount_q + 11'd1;
      v_next = vcount_q;
      if (h_wrap) begin
         v_next = v_wrap ? 11'd0 : vcount_q + 11'd1;
      end

      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      hblnk_d       = hblnk_q;
      vblnk_d       = vblnk_q;
      frame_start_d = frame_start_q;
      frame_cnt_d   = frame_cnt_q;

      if (pix_en) begin
         hcount_d      = h_next;
         vcount_d      = v_next;
         hblnk_d       = (h_next >= H_BLNK_ON);
         vblnk_d       = (v_next >= V_BLNK_ON);
         hsync_d       = ((h_next >= H_SYNC_ON) && (h_next <= H_SYNC_OFF)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync_d       = ((v_next >= V_SYNC_ON) && (v_next <= V_SYNC_OFF)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         frame_start_d = h_wrap && v_wrap;
         frame_cnt_d   = (h_wrap && v_wrap) ? frame_cnt_q + 16'd1 : frame_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_q      <= 11'd0;
         vcount_q      <= 11'd0;
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 16'd0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   // Colour is owned by the downstream draw stages; the source only supplies black.
   assign vga_out.rgb    = 12'h000;
   assign vga_out.hcount = hcount_q;
   assign vga_out.vcount = vcount_q;
   assign vga_out.hsync  = hsync_q;
   assign vga_out.vsync  = vsync_q;
   assign vga_out.hblnk  = hblnk_q;
   assign vga_out.vblnk  = vblnk_q;
   assign frame_start    = frame_start_q;
   assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size instance for line timing and a shrunken instance
// (25 x 14 total, 350 pixels per frame) for frame-level behaviour.
module tb_vga_timing_gen;

   logic clk;
   logic rst;
   logic pix_en;

   vga_if vif ();
   vga_if vif_s ();

   logic        fs_d, fs_s;
   logic [15:0] fc_d, fc_s_o;

   vga_timing_gen dut (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .vga_out     (vif),
      .frame_start (fs_d),
      .frame_cnt   (fc_d)
   );

   // Small raster: H 16+2+3+4 = 25, hsync h 18..20; V 8+1+2+3 = 14, vsync v 9..10.
   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
      .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (3),
      .SYNC_ACTIVE (1'b1)
   ) dut_s (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .vga_out     (vif_s),
      .frame_start (fs_s),
      .frame_cnt   (fc_s_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_assert;
   int          n_fail;
   int          n;
   logic [15:0] fc_s;
   int          hs_cnt;
   int          vs_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   // Expected values come from the pixel index n since the last reset release.
   task automatic check_all();
      int dh, dv, sh, sv;
      dh = n % 1344;
      dv = (n / 1344) % 806;
      sh = n % 25;
      sv = (n / 25) % 14;
      chk("d_hcount", 32'(vif.hcount), 32'(dh));
      chk("d_vcount", 32'(vif.vcount), 32'(dv));
      chk("d_hsync",  32'(vif.hsync),  32'((dh >= 1048) && (dh <= 1183)));
      chk("d_vsync",  32'(vif.vsync),  32'((dv >= 771) && (dv <= 776)));
      chk("d_hblnk",  32'(vif.hblnk),  32'(dh >= 1024));
      chk("d_vblnk",  32'(vif.vblnk),  32'(dv >= 768));
      chk("d_rgb",    32'(vif.rgb),    32'd0);
      chk("d_fstart", 32'(fs_d),       32'((n > 0) && (n % 1083264 == 0)));
      chk("d_fcnt",   32'(fc_d),       32'd0);
      chk("s_hcount", 32'(vif_s.hcount), 32'(sh));
      chk("s_vcount", 32'(vif_s.vcount), 32'(sv));
      chk("s_hsync",  32'(vif_s.hsync),  32'((sh >= 18) && (sh <= 20)));
      chk("s_vsync",  32'(vif_s.vsync),  32'((sv >= 9) && (sv <= 10)));
      chk("s_hblnk",  32'(vif_s.hblnk),  32'(sh >= 16));
      chk("s_vblnk",  32'(vif_s.vblnk),  32'(sv >= 8));
      chk("s_rgb",    32'(vif_s.rgb),    32'd0);
      chk("s_fstart", 32'(fs_s),         32'((n > 0) && (n % 350 == 0)));
      chk("s_fcnt",   32'(fc_s_o),       32'(fc_s));
   endtask

   task automatic adv(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (pix_en && !rst) begin
            n++;
            if (n % 350 == 0) fc_s++;
            if ((n <= 1344) && vif.hsync) hs_cnt++;
            if ((n <= 350) && vif_s.vsync) vs_cnt++;
         end
         check_all();
      end
   endtask

   task automatic adv_to(input int target);
      pix_en = 1'b1;
      adv(target - n);
   endtask

   // Reset lands between clock edges; outputs must clear before the next posedge.
   task automatic pulse_rst();
      #2 rst = 1'b1;
      n    = 0;
      fc_s = 16'd0;
      #1 check_all();
      @(negedge clk);
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      n        = 0;
      fc_s     = 16'd0;
      hs_cnt   = 0;
      vs_cnt   = 0;
      pix_en   = 1'b0;
      rst      = 1'b0;
      #1 rst   = 1'b1;
      #1 check_all();
      repeat (2) @(negedge clk);
      check_all();

      rst    = 1'b0;
      pix_en = 1'b1;
      adv_to(1399);
      chk("d_hsync_cycles", 32'(hs_cnt), 32'd136);
      chk("s_vsync_cycles", 32'(vs_cnt), 32'd50);

      // Stall on the last pixel of a small frame, then on the (0,0) pulse itself.
      pix_en = 1'b0;
      adv(2);
      pix_en = 1'b1;
      adv(1);
      pix_en = 1'b0;
      adv(2);
      pix_en = 1'b1;
      adv(1);

      // Mid-line, mid-frame reset outside any sync pulse (small raster h=10, v=5).
      adv_to(1535);
      pulse_rst();

      // Reset while the full-size raster is inside hsync (h=1100).
      adv_to(1100);
      pulse_rst();

      // Preload the small frame counter to 16'hFFFF, then let the frame wrap it.
      adv_to(100);
      @(posedge clk);
      force dut_s.frame_cnt_q = 16'hFFFF;
      #1 release dut_s.frame_cnt_q;
      fc_s = 16'hFFFF;
      adv(1);
      adv_to(352);
      chk("s_fcnt_wrapped", 32'(fc_s_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
